// File: rtl/cpu_pkg.sv
// Shared types for the write-back commit checker: the commit record and the
// checker's operating states.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  num;
    logic [31:0] data;
  } commit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/commit_checker_if.sv
// Commit streams around the checker: the CPU's WB-stage register writes and
// the valid/ready expected-commit stream.
interface commit_checker_if;
  logic        wb_reg_write;
  logic [31:0] wb_pc;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_pc;
  logic [4:0]  exp_num;
  logic [31:0] exp_data;

  modport master (
    output wb_reg_write, wb_pc, wb_num, wb_data,
    output exp_valid, exp_pc, exp_num, exp_data,
    input  exp_ready
  );

  modport slave (
    input  wb_reg_write, wb_pc, wb_num, wb_data,
    input  exp_valid, exp_pc, exp_num, exp_data,
    output exp_ready
  );
endinterface

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit records; the pointers carry a wrap bit so full
// and empty are distinguishable without a separate occupancy counter.
module commit_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  commit_t wdata,
  output commit_t rdata,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  commit_t     mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is taken only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: storage is deliberately not reset; the pointers alone define valid entries.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/commit_checker.sv
// In-order checker of WB-stage commits against an expected-commit stream, with
// sticky first-mismatch capture and saturating match/mismatch counters.
module commit_checker
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  commit_checker_if.slave        cif,
  output logic                   error,
  output logic                   overflow,
  output logic [31:0]            err_pc,
  output logic [31:0]            err_got_data,
  output logic [31:0]            err_exp_data,
  output logic [31:0]            commit_count,
  output logic [15:0]            mismatch_count,
  output logic                   halted
);
  state_e      state_q, state_d;
  logic        error_q, error_d;
  logic        overflow_q, overflow_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] err_got_q, err_got_d;
  logic [31:0] err_exp_q, err_exp_d;
  logic [31:0] commit_count_q, commit_count_d;
  logic [15:0] mismatch_count_q, mismatch_count_d;

  commit_t actual, expected, head;
  logic    fifo_full, fifo_empty;
  logic    push, pop, match, drop;

  assign actual   = '{pc: cif.wb_pc, num: cif.wb_num, data: cif.wb_data};
  assign expected = '{pc: cif.exp_pc, num: cif.exp_num, data: cif.exp_data};
  assign push     = (state_q == RUN) && cif.wb_reg_write;
  assign pop      = cif.exp_valid && cif.exp_ready;
  assign match    = (head == expected);
  assign drop     = push && fifo_full && !pop;

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (actual),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (drop || (pop && !match && STOP_ON_ERR)) state_d = HALT;
        else if (!enable)                           state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // exp_ready depends only on state and occupancy, never on exp_valid.
  always_comb begin
    cif.exp_ready = (state_q == RUN) && !fifo_empty;
    halted        = (state_q == HALT);
  end

  // Pops and pushes only happen in RUN, so every status register holds in HALT.
  always_comb begin
    error_d          = error_q;
    overflow_d       = overflow_q;
    err_pc_d         = err_pc_q;
    err_got_d        = err_got_q;
    err_exp_d        = err_exp_q;
    commit_count_d   = commit_count_q;
    mismatch_count_d = mismatch_count_q;
    if (pop) begin
      if (match) begin
        if (commit_count_q != '1) commit_count_d = commit_count_q + 32'd1;
      end else begin
        if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + 16'd1;
        error_d = 1'b1;
        if (!error_q) begin
          err_pc_d  = head.pc;
          err_got_d = head.data;
          err_exp_d = cif.exp_data;
        end
      end
    end
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_q          <= 1'b0;
      overflow_q       <= 1'b0;
      err_pc_q         <= '0;
      err_got_q        <= '0;
      err_exp_q        <= '0;
      commit_count_q   <= '0;
      mismatch_count_q <= '0;
    end else begin
      error_q          <= error_d;
      overflow_q       <= overflow_d;
      err_pc_q         <= err_pc_d;
      err_got_q        <= err_got_d;
      err_exp_q        <= err_exp_d;
      commit_count_q   <= commit_count_d;
      mismatch_count_q <= mismatch_count_d;
    end
  end

  assign error          = error_q;
  assign overflow       = overflow_q;
  assign err_pc         = err_pc_q;
  assign err_got_data   = err_got_q;
  assign err_exp_data   = err_exp_q;
  assign commit_count   = commit_count_q;
  assign mismatch_count = mismatch_count_q;
endmodule
